// File: rtl/hatch_timer.sv
// Machine timer: 64-bit mtime with prescaler, mtimecmp compare and level interrupt, on an OBI subordinate port.
// Latency: grant is combinational; the response (rvalid/rdata/err) follows exactly one cycle after each grant.
// Backpressure: none; gnt_o mirrors req_i, so one request is accepted every cycle and at most one response is pending.
module hatch_timer #(
   parameter int unsigned PrescaleWidth = 8,
   parameter logic        EnableOnReset = 1'b1,
   parameter logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   input  logic [5:0]  atop_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        exokay_o,
   output logic [63:0] mtime_o,
   output logic        timer_irq_o
);

   // Word offsets within the 32-byte window (addr_i[4:2]).
   localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
   localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] OFF_CTRL        = 3'd4;
   localparam logic [2:0] OFF_STATUS      = 3'd5;

   localparam logic [PrescaleWidth-1:0] PSC_ZERO = '0;
   localparam logic [PrescaleWidth-1:0] PSC_ONE  = {{(PrescaleWidth-1){1'b0}}, 1'b1};

   // Architectural state.
   logic [63:0]              r_mtime;
   logic [63:0]              r_mtimecmp;
   logic                     r_enable;
   logic [PrescaleWidth-1:0] r_prescale;
   logic [PrescaleWidth-1:0] r_psc_cnt;
   logic                     r_irq;

   // Response state.
   logic                     r_rvalid;
   logic [31:0]              r_rdata;
   logic                     r_err;

   // Decode and access qualification.
   logic [2:0]  w_off;
   logic        w_unmapped;
   logic        w_err;
   logic        w_wr;
   logic        w_wr_mtime_lo;
   logic        w_wr_mtime_hi;
   logic        w_wr_cmp_lo;
   logic        w_wr_cmp_hi;
   logic        w_wr_ctrl;
   logic        w_tick;
   logic [31:0] w_ctrl_rd;
   logic [31:0] w_ctrl_new;
   logic [31:0] w_rd;
   logic [63:0] w_mtime_nxt;
   logic [63:0] w_mtimecmp_nxt;
   logic        w_unused;

   // Only addr_i[4:2] selects a register; the rest of the address is ignored.
   assign w_unused = ^{addr_i[31:5], addr_i[1:0]};

   // Merge write data into a 32-bit word one byte lane at a time.
   function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            res[8*b +: 8] = new_w[8*b +: 8];
         end
      end
      return res;
   endfunction

   assign w_off      = addr_i[4:2];
   assign w_unmapped = (w_off > OFF_STATUS);
   assign w_err      = w_unmapped || (atop_i != 6'd0);

   // A write with no byte enables is a no-op, so it neither suppresses ticks nor clears the prescaler.
   assign w_wr          = req_i && we_i && !w_err && (be_i != 4'd0);
   assign w_wr_mtime_lo = w_wr && (w_off == OFF_MTIME_LO);
   assign w_wr_mtime_hi = w_wr && (w_off == OFF_MTIME_HI);
   assign w_wr_cmp_lo   = w_wr && (w_off == OFF_MTIMECMP_LO);
   assign w_wr_cmp_hi   = w_wr && (w_off == OFF_MTIMECMP_HI);
   assign w_wr_ctrl     = w_wr && (w_off == OFF_CTRL);

   // The prescale counter reaching the programmed value marks one mtime increment.
   assign w_tick = r_enable && (r_psc_cnt == r_prescale);

   // CTRL as seen on the bus: bit0 enable, prescale field from bit 8 upward, all other bits zero.
   always_comb begin
      w_ctrl_rd                       = '0;
      w_ctrl_rd[0]                    = r_enable;
      w_ctrl_rd[8 +: PrescaleWidth]   = r_prescale;
   end

   assign w_ctrl_new = f_merge(w_ctrl_rd, wdata_i, be_i);

   // Next mtime: a software write to either half wins and blocks the whole increment, carry included.
   always_comb begin
      w_mtime_nxt = r_mtime;
      if (w_wr_mtime_lo || w_wr_mtime_hi) begin
         if (w_wr_mtime_lo) begin
            w_mtime_nxt[31:0] = f_merge(r_mtime[31:0], wdata_i, be_i);
         end
         if (w_wr_mtime_hi) begin
            w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], wdata_i, be_i);
         end
      end else if (w_tick) begin
         w_mtime_nxt = r_mtime + 64'd1;
      end
   end

   // Next mtimecmp: byte-masked writes to either half.
   always_comb begin
      w_mtimecmp_nxt = r_mtimecmp;
      if (w_wr_cmp_lo) begin
         w_mtimecmp_nxt[31:0] = f_merge(r_mtimecmp[31:0], wdata_i, be_i);
      end
      if (w_wr_cmp_hi) begin
         w_mtimecmp_nxt[63:32] = f_merge(r_mtimecmp[63:32], wdata_i, be_i);
      end
   end

   // Read mux over current register values, i.e. before this cycle's increment lands.
   always_comb begin
      w_rd = '0;
      case (w_off)
         OFF_MTIME_LO:    w_rd = r_mtime[31:0];
         OFF_MTIME_HI:    w_rd = r_mtime[63:32];
         OFF_MTIMECMP_LO: w_rd = r_mtimecmp[31:0];
         OFF_MTIMECMP_HI: w_rd = r_mtimecmp[63:32];
         OFF_CTRL:        w_rd = w_ctrl_rd;
         OFF_STATUS:      w_rd = {31'd0, r_irq};
         default:         w_rd = '0;
      endcase
   end

   // mtime and mtimecmp registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mtime    <= '0;
         r_mtimecmp <= MtimecmpReset;
      end else begin
         r_mtime    <= w_mtime_nxt;
         r_mtimecmp <= w_mtimecmp_nxt;
      end
   end

   // CTRL fields; bits outside enable and prescale are discarded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_enable   <= EnableOnReset;
         r_prescale <= PSC_ZERO;
      end else if (w_wr_ctrl) begin
         r_enable   <= w_ctrl_new[0];
         r_prescale <= w_ctrl_new[8 +: PrescaleWidth];
      end
   end

   // Prescale counter: restarts on any CTRL write so a new divisor takes effect from a clean phase.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_psc_cnt <= PSC_ZERO;
      end else if (w_wr_ctrl) begin
         r_psc_cnt <= PSC_ZERO;
      end else if (r_enable) begin
         if (w_tick) begin
            r_psc_cnt <= PSC_ZERO;
         end else begin
            r_psc_cnt <= r_psc_cnt + PSC_ONE;
         end
      end
   end

   // Interrupt level from the registered compare; it trails the registers by one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= (r_mtime >= r_mtimecmp);
      end
   end

   // One-cycle response; rdata is zero for writes and errors and holds between responses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= req_i;
         r_err    <= req_i && w_err;
         if (req_i) begin
            r_rdata <= (we_i || w_err) ? 32'd0 : w_rd;
         end
      end
   end

   assign gnt_o       = req_i;
   assign rvalid_o    = r_rvalid;
   assign rdata_o     = r_rdata;
   assign err_o       = r_err;
   assign exokay_o    = 1'b0;
   assign mtime_o     = r_mtime;
   assign timer_irq_o = r_irq;

endmodule
